load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 57 +++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   funct3 encodings for RISC-V loads/stores, completion status codes,
//   the controller state enum and the request legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_t;

  // Classifies a request before any memory access is made. An illegal
  // funct3 wins over misalignment since its access size is undefined.
  function automatic logic [1:0] access_check(input logic       is_store,
                                              input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
    logic legal;
    legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
            (!is_store && ((funct3 == F3_BU) || (funct3 == F3_HU)));
    if (!legal)
      return ERR_ILLEGAL;
    else if ((funct3[1:0] == 2'b01) && addr_lo[0])
      return ERR_MISALIGN;
    else if ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00))
      return ERR_MISALIGN;
    else
      return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane logic for the load/store unit.
//   funct3     : access size/sign code
//   addr_lo    : byte offset within the word
//   wdata      : store data from the core
//   mem_rdata  : word returned by memory
//   be         : byte enables for the access
//   store_data : store data replicated into the addressed lanes
//   load_data  : selected lane, sign- or zero-extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  // Byte and halfword stores replicate their data across the word so the
  // byte enables alone pick the destination lane.
  always_comb begin
    be         = 4'b1111;
    store_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        store_data = wdata;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by funct3.
  always_comb begin
    lane      = mem_rdata >> {addr_lo, 3'b000};
    load_data = lane;
    case (funct3)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   load_data = {24'h000000, lane[7:0]};
      F3_HU:   load_data = {16'h0000, lane[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- single-outstanding RISC-V load/store unit.
//   clk, rst (async, active low)
//   core side  : start, is_store, funct3, addr, wdata -> busy, done, rdata, err
//   memory side: mem_req, mem_we, mem_addr, mem_be, mem_wdata <- mem_ack, mem_rdata
// Optional feature: define LSU_TIMEOUT_EN to abort a request that waits
// MAX_WAIT cycles in REQ without mem_ack (err = 11).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_next;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  sel_funct3;
  logic [1:0]  sel_addr_lo;
  logic [3:0]  be_calc;
  logic [31:0] store_calc;
  logic [31:0] load_calc;
  logic [1:0]  check;
  logic        capture;
  logic        timeout_hit;

  assign check   = access_check(is_store, funct3, addr[1:0]);
  assign capture = (state == IDLE) && start;

  // The lane logic sees the live request while idle (to build the store
  // lanes) and the captured request afterwards (to extend the load data).
  assign sel_funct3  = (state == IDLE) ? funct3    : funct3_q;
  assign sel_addr_lo = (state == IDLE) ? addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .funct3     (sel_funct3),
    .addr_lo    (sel_addr_lo),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .be         (be_calc),
    .store_data (store_calc),
    .load_data  (load_calc)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  logic [CW-1:0] wait_cnt;

  // Counts REQ cycles without an ack; held at zero outside REQ so every
  // new request starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt <= '0;
    else if (state != REQ)
      wait_cnt <= '0;
    else if (!mem_ack)
      wait_cnt <= wait_cnt + CW'(1);
  end

  assign timeout_hit = (state == REQ) && !mem_ack && (wait_cnt == CW'(MAX_WAIT - 1));
`else
  // No watchdog: REQ waits for mem_ack indefinitely. The comparison is
  // constant false for any legal MAX_WAIT.
  assign timeout_hit = (MAX_WAIT < 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = (check == ERR_OK) ? REQ : RESP;
      end
      REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack || timeout_hit)
          state_next = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side fields are registered at capture so they stay stable for
  // the whole request; rdata/err change only on the edge that raises done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      funct3_q  <= '0;
      addr_lo_q <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      err       <= ERR_OK;
    end else if (capture) begin
      if (check == ERR_OK) begin
        funct3_q  <= funct3;
        addr_lo_q <= addr[1:0];
        mem_we    <= is_store;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= be_calc;
        mem_wdata <= store_calc;
      end else begin
        err <= check;
      end
    end else if (state == REQ) begin
      if (mem_ack) begin
        err <= ERR_OK;
        if (!mem_we)
          rdata <= load_calc;
      end else if (timeout_hit) begin
        err <= ERR_TIMEOUT;
      end
    end
  end

endmodule
